gpio_stimulus_gen: RTL and testbench

Synthesizable, parametrised pattern generator that drives a GPIO-width bus (e.g. the demo's gpio_b switch input) with a timed stimulus sequence. Replaces the fixed "increment every N ns" bench stimulus with selectable sequence modes: up-count, down-count, walking-one and maximal LFSR. Also supports synchronous load, forced step and wrap reporting. Used both in demo benches and on-board as a self-test source for the GPIO path of the core.

---
 rtl/gpio_stimulus_gen_if.sv | 24 ++
 rtl/gpio_stimulus_gen.sv | 109 ++++++++++
 tb/tb_gpio_stimulus_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_stimulus_gen_if.sv
// Control/data bundle for the GPIO stimulus generator.
// master drives the controls and observes the stimulus; slave is the generator.
interface gpio_stimulus_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enable;
  logic [1:0]            mode;
  logic                  step_now;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  step_pulse;
  logic                  wrap;

  modport master (
    output enable, mode, step_now, load, load_data,
    input  data_out, step_pulse, wrap
  );

  modport slave (
    input  enable, mode, step_now, load, load_data,
    output data_out, step_pulse, wrap
  );
endinterface

// File: rtl/gpio_stimulus_gen.sv
// Timed GPIO stimulus generator: up / down / walking-one / Galois LFSR sequences
// advanced by a period timer or a forced step, with synchronous load.
// data_out, step_pulse and wrap all update on the same edge as the step.
module gpio_stimulus_gen #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    PERIOD      = 1000,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS   = DATA_WIDTH'(8'hB8)
) (
  input  logic                clk,
  input  logic                reset,
  gpio_stimulus_gen_if.slave  bus
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0]         TLAST = TW'(PERIOD - 1);
  localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO  = '0;

  localparam logic [1:0] M_UP   = 2'd0;
  localparam logic [1:0] M_DOWN = 2'd1;
  localparam logic [1:0] M_WALK = 2'd2;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  pulse_q, pulse_d;
  logic                  wrap_q, wrap_d;

  logic [DATA_WIDTH-1:0] seq_nxt;
  logic                  seq_wrap;
  logic                  tick;
  logic                  step;

  // PERIOD=1 keeps the timer at 0 with TLAST=0, so every enabled cycle ticks.
  assign tick = bus.enable && (timer_q == TLAST);
  assign step = tick || bus.step_now;

  // Sequence successor of the current value under the current mode.
  always_comb begin
    seq_nxt  = data_q;
    seq_wrap = 1'b0;
    case (bus.mode)
      M_UP: begin
        seq_nxt  = data_q + ONE;
        seq_wrap = &data_q;
      end
      M_DOWN: begin
        seq_nxt  = data_q - ONE;
        seq_wrap = ~|data_q;
      end
      M_WALK: begin
        if (data_q == ZERO) begin
          seq_nxt = ONE;
        end else begin
          seq_nxt  = {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
          seq_wrap = data_q[DATA_WIDTH-1];
        end
      end
      default: begin
        // All-zero is the LFSR lockup state; escape to 1 without reporting a wrap.
        if (data_q == ZERO) begin
          seq_nxt = ONE;
        end else begin
          seq_nxt  = (data_q >> 1) ^ (data_q[0] ? LFSR_TAPS : ZERO);
          seq_wrap = (seq_nxt == ONE);
        end
      end
    endcase
  end

  // Load beats step; any step or load restarts the period timer.
  always_comb begin
    data_d  = data_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    wrap_d  = 1'b0;
    if (bus.load) begin
      data_d  = bus.load_data;
      timer_d = '0;
    end else if (step) begin
      data_d  = seq_nxt;
      timer_d = '0;
      pulse_d = 1'b1;
      wrap_d  = seq_wrap;
    end else if (bus.enable) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= RESET_VALUE;
      timer_q <= '0;
      pulse_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.step_pulse = pulse_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_gpio_stimulus_gen.sv
// Bench for gpio_stimulus_gen: an integer reference model checked every cycle,
// plus hand-computed expectations along the directed stimulus.
module tb_gpio_stimulus_gen;
  localparam int W      = 8;
  localparam int PERIOD = 4;
  localparam int TAPS   = 'hB8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_on = 1'b0;

  gpio_stimulus_gen_if #(.DATA_WIDTH(W)) bus();

  gpio_stimulus_gen #(
    .DATA_WIDTH (W),
    .PERIOD     (PERIOD),
    .RESET_VALUE(8'h00),
    .LFSR_TAPS  (8'hB8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sequence rules in plain integer arithmetic.
  function automatic int ref_next(input int d, input int m);
    case (m)
      0:       return (d + 1) % 256;
      1:       return (d + 255) % 256;
      2:       return (d == 0) ? 1 : (((d << 1) | (d >> 7)) & 255);
      default: return (d == 0) ? 1 : ((d >> 1) ^ (((d & 1) != 0) ? TAPS : 0));
    endcase
  endfunction

  function automatic bit ref_wrap(input int d, input int m);
    case (m)
      0:       return d == 255;
      1:       return d == 0;
      2:       return d >= 128;
      default: return (d != 0) && (ref_next(d, 3) == 1);
    endcase
  endfunction

  int m_data, m_cnt;
  bit m_pulse, m_wrap;

  // m_cnt = enabled cycles since the last step/load.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data <= 0; m_cnt <= 0; m_pulse <= 0; m_wrap <= 0;
    end else if (bus.load) begin
      m_data <= int'(bus.load_data); m_cnt <= 0; m_pulse <= 0; m_wrap <= 0;
    end else if ((bus.enable && m_cnt == PERIOD - 1) || bus.step_now) begin
      m_data  <= ref_next(m_data, int'(bus.mode));
      m_wrap  <= ref_wrap(m_data, int'(bus.mode));
      m_pulse <= 1;
      m_cnt   <= 0;
    end else begin
      m_pulse <= 0; m_wrap <= 0;
      if (bus.enable) m_cnt <= m_cnt + 1;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_data", int'(bus.data_out), m_data);
      chk("model_pulse", int'(bus.step_pulse), int'(m_pulse));
      chk("model_wrap", int'(bus.wrap), int'(m_wrap));
    end
  end

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic lit(input string name, input int d, input int p, input int w);
    chk({name, "_data"}, int'(bus.data_out), d);
    chk({name, "_pulse"}, int'(bus.step_pulse), p);
    chk({name, "_wrap"}, int'(bus.wrap), w);
  endtask

  logic [255:0] seen;
  bit dup;

  initial begin
    bus.enable = 0; bus.mode = 2'd0; bus.step_now = 0; bus.load = 0; bus.load_data = '0;
    tick_n(3);
    lit("reset", 0, 0, 0);
    reset = 0; bus.enable = 1; cmp_on = 1;

    // Period timing
    for (int i = 0; i < 3; i++) begin tick_n(1); lit("per_hold0", 0, 0, 0); end
    tick_n(1); lit("per_step1", 1, 1, 0);
    tick_n(3); lit("per_hold1", 1, 0, 0);
    tick_n(1); lit("per_step2", 2, 1, 0);
    tick_n(2);
    bus.enable = 0; tick_n(10); lit("en_frozen", 2, 0, 0);
    bus.enable = 1; tick_n(1); lit("en_resume", 2, 0, 0);
    tick_n(1); lit("en_step3", 3, 1, 0);

    // Up/down wrap
    bus.enable = 0; bus.load = 1; bus.load_data = 8'hFE; tick_n(1);
    bus.load = 0; lit("ud_load", 'hFE, 0, 0);
    bus.step_now = 1;
    tick_n(1); lit("up_ff", 'hFF, 1, 0);
    tick_n(1); lit("up_wrap", 'h00, 1, 1);
    bus.mode = 2'd1;
    tick_n(1); lit("dn_wrap", 'hFF, 1, 1);
    tick_n(1); lit("dn_fe", 'hFE, 1, 0);
    bus.step_now = 0;

    // Walking-one
    bus.load = 1; bus.load_data = 8'h00; bus.mode = 2'd2; tick_n(1);
    bus.load = 0; bus.step_now = 1;
    for (int i = 0; i < 8; i++) begin tick_n(1); lit("walk", 1 << i, 1, 0); end
    tick_n(1); lit("walk_wrap", 1, 1, 1);
    bus.step_now = 0; bus.load = 1; tick_n(1);
    bus.load = 0; bus.step_now = 1; tick_n(1); lit("walk_zero", 1, 1, 0);
    bus.step_now = 0;

    // LFSR full cycle
    bus.load = 1; bus.load_data = 8'h01; bus.mode = 2'd3; tick_n(1);
    bus.load = 0; bus.step_now = 1;
    seen = '0; seen[1] = 1'b1; dup = 0;
    for (int i = 1; i <= 255; i++) begin
      tick_n(1);
      if (i == 1) lit("lfsr_1", 'hB8, 1, 0);
      if (i == 2) lit("lfsr_2", 'h5C, 1, 0);
      if (i < 255) begin
        if (seen[bus.data_out]) dup = 1;
        seen[bus.data_out] = 1'b1;
      end
    end
    lit("lfsr_255", 1, 1, 1);
    chk("lfsr_unique", int'(dup), 0);
    chk("lfsr_seen_all", int'(&seen[255:1]), 1);
    bus.step_now = 0; bus.load = 1; bus.load_data = 8'h00; tick_n(1);
    bus.load = 0; bus.step_now = 1; tick_n(1); lit("lfsr_lockup", 1, 1, 0);
    bus.step_now = 0;

    // Collisions: load + step_now + tick together
    bus.mode = 2'd0; bus.enable = 1; bus.load = 1; bus.load_data = 8'h20; tick_n(1);
    bus.load = 0; tick_n(2);
    bus.load = 1; bus.load_data = 8'h10; bus.step_now = 1; tick_n(1);
    bus.load = 0; bus.step_now = 0; lit("coll_load", 'h10, 0, 0);
    tick_n(3); lit("coll_hold", 'h10, 0, 0);
    tick_n(1); lit("coll_tick", 'h11, 1, 0);
    tick_n(1);
    bus.step_now = 1; tick_n(1); lit("force_step", 'h12, 1, 0);
    bus.step_now = 0;
    tick_n(3); lit("force_hold", 'h12, 0, 0);
    tick_n(1); lit("force_next", 'h13, 1, 0);

    // Asynchronous reset mid-operation
    bus.step_now = 1; tick_n(5);
    @(posedge clk); #2;
    reset = 1; #1;
    lit("async_rst", 0, 0, 0);
    bus.step_now = 0;
    tick_n(2);
    reset = 0;
    for (int i = 0; i < 3; i++) begin tick_n(1); lit("rst_hold", 0, 0, 0); end
    tick_n(1); lit("rst_first", 1, 1, 0);

    cmp_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
